// File: rtl/conv_window_gen.sv
// Sliding K x K window generator for a raster-order pixel stream (stride 1, no padding).
// K-1 line delays feed the new right-hand column of the window; row/col counters gate validity.
module conv_window_gen #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IMG_W      = 14,
    parameter int unsigned IMG_H      = 14,
    parameter int unsigned K          = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          valid_i,
    input  logic [DATA_WIDTH-1:0]         data_i,
    output logic [K*K*DATA_WIDTH-1:0]     window_o,
    output logic                          valid_o,
    output logic                          last_o,
    output logic                          frame_done_o
);

    localparam int unsigned CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int          KI  = int'(K);
    localparam int          DWI = int'(DATA_WIDTH);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0]            r_col;
    logic [RW-1:0]            r_row;
    logic [K*DATA_WIDTH-1:0]  w_col;
    logic                     w_pos_ok;
    logic                     w_last;

    assign w_last = (r_row == ROW_LAST) && (r_col == COL_LAST);

    generate
        if (K > 1) begin : g_lines
            localparam int          LINES = KI - 1;
            localparam int          WI    = int'(IMG_W);
            localparam logic [CW-1:0] COL_KM1 = CW'(K - 1);
            localparam logic [RW-1:0] ROW_KM1 = RW'(K - 1);

            logic [DATA_WIDTH-1:0] r_line [K-1][IMG_W];

            // Line delays carry no reset: their stale contents are masked by the counters.
            always_ff @(posedge clk) begin
                if (valid_i) begin
                    r_line[0][0] <= data_i;
                    for (int l = 1; l < LINES; l++) begin
                        r_line[l][0] <= r_line[l-1][WI-1];
                    end
                    for (int l = 0; l < LINES; l++) begin
                        for (int e = 1; e < WI; e++) begin
                            r_line[l][e] <= r_line[l][e-1];
                        end
                    end
                end
            end

            // Deepest line delay holds the oldest row, so it lands in window row 0.
            for (genvar i = 0; i < KI - 1; i++) begin : g_col
                assign w_col[i*DWI +: DWI] = r_line[KI-2-i][WI-1];
            end
            assign w_col[(KI-1)*DWI +: DWI] = data_i;

            assign w_pos_ok = (r_row >= ROW_KM1) && (r_col >= COL_KM1);
        end else begin : g_nolines
            assign w_col    = data_i;
            assign w_pos_ok = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            window_o     <= '0;
            valid_o      <= 1'b0;
            last_o       <= 1'b0;
            frame_done_o <= 1'b0;
            r_col        <= '0;
            r_row        <= '0;
        end else begin
            valid_o      <= valid_i && w_pos_ok;
            last_o       <= valid_i && w_last;
            frame_done_o <= valid_i && w_last;
            if (valid_i) begin
                for (int i = 0; i < KI; i++) begin
                    for (int j = 0; j < KI - 1; j++) begin
                        window_o[(i*KI+j)*DWI +: DWI] <= window_o[(i*KI+j+1)*DWI +: DWI];
                    end
                    window_o[(i*KI+KI-1)*DWI +: DWI] <= w_col[i*DWI +: DWI];
                end
                if (r_col == COL_LAST) begin
                    r_col <= '0;
                    r_row <= (r_row == ROW_LAST) ? '0 : r_row + RW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: default 14x14 K=3 instance plus 8x6 K=1 and K=5 instances.
module tb_conv_window_gen;

    localparam int DW = 8;
    localparam int W  = 14;
    localparam int H  = 14;
    localparam int K  = 3;
    localparam int SW = 8;
    localparam int SH = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic               valid_i;
    logic [DW-1:0]      data_i;
    logic [K*K*DW-1:0]  window_o;
    logic               valid_o, last_o, frame_done_o;

    logic               s_valid;
    logic [DW-1:0]      s_data;
    logic [DW-1:0]      w1;
    logic               v1, l1, f1;
    logic [25*DW-1:0]   w5;
    logic               v5, l5, f5;

    conv_window_gen #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H), .K(K)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .data_i(data_i),
        .window_o(window_o), .valid_o(valid_o), .last_o(last_o), .frame_done_o(frame_done_o));

    conv_window_gen #(.DATA_WIDTH(DW), .IMG_W(SW), .IMG_H(SH), .K(1)) dut_k1 (
        .clk(clk), .rst_n(rst_n), .valid_i(s_valid), .data_i(s_data),
        .window_o(w1), .valid_o(v1), .last_o(l1), .frame_done_o(f1));

    conv_window_gen #(.DATA_WIDTH(DW), .IMG_W(SW), .IMG_H(SH), .K(5)) dut_k5 (
        .clk(clk), .rst_n(rst_n), .valid_i(s_valid), .data_i(s_data),
        .window_o(w5), .valid_o(v5), .last_o(l5), .frame_done_o(f5));

    int errors = 0;
    int checks = 0;

    int mr, mc, acc_cnt, obs_valid, obs_last, obs_fd, first_acc;
    logic got_first, hold_valid;
    logic [K*K*DW-1:0] first_win, last_win, exp_hold;

    function automatic logic [DW-1:0] pix(int r, int c, int w, int base);
        return DW'(r * w + c + base);
    endfunction

    function automatic logic [K*K*DW-1:0] model3(int r, int c, int base);
        logic [K*K*DW-1:0] m;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                m[(i*K+j)*DW +: DW] = pix(r - K + 1 + i, c - K + 1 + j, W, base);
        return m;
    endfunction

    function automatic logic [25*DW-1:0] model5(int r, int c);
        logic [25*DW-1:0] m;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                m[(i*5+j)*DW +: DW] = pix(r - 4 + i, c - 4 + j, SW, 0);
        return m;
    endfunction

    function automatic logic [K*K*DW-1:0] pack9(int a0, int a1, int a2, int a3, int a4,
                                                int a5, int a6, int a7, int a8);
        return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    task automatic check(input string tag, input logic [25*DW-1:0] obs, input logic [25*DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        acc_cnt = 0; obs_valid = 0; obs_last = 0; obs_fd = 0;
        first_acc = -1; got_first = 1'b0;
        first_win = '0; last_win = '0;
    endtask

    // One cycle on the default instance; expectations come from the raster-position model.
    task automatic step(input logic v, input int base);
        logic ev, el;
        logic [K*K*DW-1:0] ew;
        valid_i = v;
        data_i  = v ? pix(mr, mc, W, base) : DW'($urandom);
        @(posedge clk); #1;
        ev = 1'b0; el = 1'b0; ew = '0;
        if (v) begin
            ev = (mr >= K - 1) && (mc >= K - 1);
            el = (mr == H - 1) && (mc == W - 1);
            ew = model3(mr, mc, base);
            acc_cnt++;
            if (mc == W - 1) begin mc = 0; mr = (mr == H - 1) ? 0 : mr + 1; end
            else mc = mc + 1;
        end
        check("valid_o", valid_o, ev);
        check("last_o", last_o, el);
        check("frame_done_o", frame_done_o, el);
        if (ev) check("window", window_o, ew);
        if (!v && hold_valid) check("window_hold", window_o, exp_hold);
        if (v) begin hold_valid = ev; exp_hold = ew; end
        if (valid_o) begin
            obs_valid++;
            if (!got_first) begin got_first = 1'b1; first_acc = acc_cnt; first_win = window_o; end
        end
        if (last_o) begin obs_last++; last_win = window_o; end
        if (frame_done_o) obs_fd++;
        valid_i = 1'b0;
    endtask

    task automatic check_frame(input string tag, input logic [K*K*DW-1:0] fw, input logic [K*K*DW-1:0] lw);
        check({tag, "_windows"}, 200'(obs_valid), 200'(144));
        check({tag, "_last_cnt"}, 200'(obs_last), 200'(1));
        check({tag, "_done_cnt"}, 200'(obs_fd), 200'(1));
        check({tag, "_first_at"}, 200'(first_acc), 200'(31));
        check({tag, "_first_win"}, first_win, fw);
        check({tag, "_last_win"}, last_win, lw);
    endtask

    int sr, sc, n1, n5, guard;
    logic [K*K*DW-1:0] fw0, lw0, fw100, lw100;

    initial begin
        fw0   = pack9(0, 1, 2, 14, 15, 16, 28, 29, 30);
        lw0   = pack9(165, 166, 167, 179, 180, 181, 193, 194, 195);
        fw100 = pack9(100, 101, 102, 114, 115, 116, 128, 129, 130);
        lw100 = pack9(265, 266, 267, 279, 280, 281, 293, 294, 295);
        rst_n = 1'b0; valid_i = 1'b0; data_i = '0; s_valid = 1'b0; s_data = '0;
        mr = 0; mc = 0; hold_valid = 1'b0; exp_hold = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", valid_o, 1'b0);
        check("rst_last", last_o, 1'b0);
        check("rst_done", frame_done_o, 1'b0);
        check("rst_window", window_o, '0);
        rst_n = 1'b1;

        // Continuous frame.
        clear_stats();
        for (int p = 0; p < H * W; p++) step(1'b1, 0);
        check_frame("cont", fw0, lw0);

        // Same frame with random idle cycles.
        clear_stats();
        guard = 0;
        while (acc_cnt < H * W && guard < 3000) begin
            step(1'($urandom_range(0, 1)), 0);
            guard++;
        end
        check("gap_accepted", 200'(acc_cnt), 200'(H * W));
        check("gap_windows", 200'(obs_valid), 200'(144));
        check("gap_last_win", last_win, lw0);

        // Back-to-back frames, second offset by 100.
        clear_stats();
        for (int p = 0; p < H * W; p++) step(1'b1, 0);
        check_frame("b2b_a", fw0, lw0);
        clear_stats();
        for (int p = 0; p < H * W; p++) step(1'b1, 100);
        check_frame("b2b_b", fw100, lw100);

        // Reset after 50 pixels, then a fresh frame.
        for (int p = 0; p < 50; p++) step(1'b1, 0);
        rst_n = 1'b0; valid_i = 1'b1; data_i = 8'hA5;
        @(posedge clk); #1;
        check("mid_rst_valid", valid_o, 1'b0);
        check("mid_rst_last", last_o, 1'b0);
        check("mid_rst_done", frame_done_o, 1'b0);
        check("mid_rst_window", window_o, '0);
        rst_n = 1'b1; valid_i = 1'b0;
        mr = 0; mc = 0; hold_valid = 1'b0;
        clear_stats();
        for (int p = 0; p < H * W; p++) step(1'b1, 0);
        check_frame("post_rst", fw0, lw0);

        // K=1 and K=5 on an 8x6 image, idle every fourth cycle.
        sr = 0; sc = 0; n1 = 0; n5 = 0;
        for (int cyc = 0; sr * SW + sc < SH * SW && cyc < 200; cyc++) begin
            logic v, e5, el;
            logic [DW-1:0] ep;
            logic [25*DW-1:0] ew5;
            v = (cyc % 4) != 3;
            s_valid = v;
            s_data  = v ? pix(sr, sc, SW, 0) : DW'($urandom);
            ep = s_data;
            @(posedge clk); #1;
            e5 = v && (sr >= 4) && (sc >= 4);
            el = v && (sr == SH - 1) && (sc == SW - 1);
            ew5 = model5(sr, sc);
            check("k1_valid", v1, v);
            if (v) check("k1_window", w1, ep);
            check("k1_last", l1, el);
            check("k5_valid", v5, e5);
            if (e5) check("k5_window", w5, ew5);
            check("k5_last", l5, el);
            check("k5_done", f5, el);
            if (v1) n1++;
            if (v5) n5++;
            if (v) begin
                if (sc == SW - 1) begin sc = 0; sr = sr + 1; end
                else sc = sc + 1;
            end
        end
        s_valid = 1'b0;
        check("k1_windows", 200'(n1), 200'(48));
        check("k5_windows", 200'(n5), 200'(8));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
